assignment3: RTL and testbench
==============================

ASSIGNMENT3 -- requirements
Module: assignment3

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset; synchronous, active-low; sampled only on the rising edge of clock.
REQ-004 in  input  8  unsigned operand, buffered one cycle before use.
REQ-005 op  input  2  operation select, used unbuffered at each edge.
REQ-006 out  output  9  unsigned result; driven directly from a register.

Function
REQ-007 The block SHALL hold an 8-bit operand register A and a 9-bit output register R, with out = R at all times.
REQ-008 On each rising edge with reset_n high, A SHALL load in.
REQ-009 On the same edge, R SHALL load f(A_prev, op), where A_prev is A's value before this edge and op is its value at this edge.
REQ-010 Latency SHALL be 2 edges from in to out and 1 edge from op to out.
REQ-011 f with op=0 SHALL be pass-through: zero-extend A to 9 bits.
REQ-012 f with op=1 SHALL be A + 2, computed at 9 bits with no overflow (max 257).
REQ-013 f with op=2 SHALL be A shifted left by 1, computed at 9 bits with no bit loss (max 510).
REQ-014 f with op=3 SHALL be the population count of A, i.e. the number of 1 bits (range 0..8), zero-extended to 9 bits.
REQ-015 A change of op between edges SHALL affect only the next edge; no combinational path from in or op to out is permitted.
REQ-016 An unchanged op and in SHALL yield a stable out after the pipeline fills.
REQ-017 No handshake or valid signal SHALL exist; every edge produces a result.

Reset
REQ-018 On a rising edge with reset_n low, A and R SHALL both be cleared to 0, so out = 0 after that edge; reset takes priority over all other updates.
REQ-019 Reset asserted mid-operation SHALL discard the in value captured on earlier edges.
REQ-020 On the first edge after reset_n returns high, out SHALL be f(0, op): 0, 2, 0 or 0 for op = 0, 1, 2, 3.
REQ-021 out SHALL be undefined until the first reset edge; benches SHALL apply reset before checking.

Verification
REQ-022 Buffering: reset, op=0, in=0 for one edge, then in=9 -> out=0 after the next edge and out=9 after the following edge.
REQ-023 Op sequence with A=9 -> op=1 gives out=11; op=2 gives out=18; op=3 gives out=2, each after one edge.
REQ-024 Popcount pipeline: with op=3 and A=9, set in=143 -> out=2 after the first edge and out=5 after the second edge.
REQ-025 Width boundaries: in=255 -> op=0 gives 255, op=1 gives 257, op=2 gives 510, op=3 gives 8; in=0 with op=3 gives 0.
REQ-026 Reset mid-stream: A=200, op=2, reset_n low for one edge -> out=0; after reset_n goes high with in=0 and op=2 -> out=0.
REQ-027 Random regression: for random in and op over 1000 or more edges, out SHALL match a reference model implementing REQ-008 to REQ-014 on every edge.

Source files
------------

// File: rtl/assignment3.sv
// Two-stage operand/result pipeline: the input byte is registered, then one of
// four arithmetic functions selected by op is applied and registered onto out.
module assignment3 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] in,
    input  logic [1:0] op,
    output logic [8:0] out
);

    typedef enum logic [1:0] {
        OP_PASS   = 2'd0,
        OP_ADD2   = 2'd1,
        OP_SHL1   = 2'd2,
        OP_POPCNT = 2'd3
    } op_e;

    logic [7:0] r_a;
    logic [8:0] r_result;
    logic [8:0] w_f;
    logic [3:0] w_popcnt;
    op_e        w_op;

    assign w_op = op_e'(op);

    always_comb begin
        w_popcnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_popcnt = w_popcnt + {3'd0, r_a[i]};
        end
    end

    // All results are formed at 9 bits so the +2 carry and the shifted-out MSB survive.
    always_comb begin
        w_f = 9'd0;
        unique case (w_op)
            OP_PASS:   w_f = {1'b0, r_a};
            OP_ADD2:   w_f = {1'b0, r_a} + 9'd2;
            OP_SHL1:   w_f = {r_a, 1'b0};
            OP_POPCNT: w_f = {5'd0, w_popcnt};
            default:   w_f = 9'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_a      <= 8'd0;
            r_result <= 9'd0;
        end else begin
            r_a      <= in;
            r_result <= w_f;
        end
    end

    assign out = r_result;

endmodule

// File: tb/tb_assignment3.sv
// Scoreboard bench for assignment3: directed vectors carry hand-computed
// expectations, the random phase uses a small reference model.
module tb_assignment3;

    logic       clock;
    logic       reset_n;
    logic [7:0] in;
    logic [1:0] op;
    logic [8:0] out;

    int vectors     = 0;
    int miscompares = 0;

    logic [8:0] expQ[$];
    string      tagQ[$];
    logic [7:0] modelA;

    assignment3 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .in      (in),
        .op      (op),
        .out     (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [8:0] refF(input logic [7:0] a, input logic [1:0] o);
        case (o)
            2'd0:    return {1'b0, a};
            2'd1:    return 9'(a) + 9'd2;
            2'd2:    return 9'(a) * 9'd2;
            default: return 9'($countones(a));
        endcase
    endfunction

    // Drive one edge's inputs, push the expected out, then pop and compare after the edge.
    task automatic applyStimulus(input logic [7:0] vin, input logic [1:0] vop, input logic vrst,
                                 input logic useModel, input logic [8:0] expFixed, input string tag);
        logic [8:0] expv;
        logic [8:0] popped;
        string      ptag;
        in      = vin;
        op      = vop;
        reset_n = vrst;
        expv    = !vrst ? 9'd0 : (useModel ? refF(modelA, vop) : expFixed);
        expQ.push_back(expv);
        tagQ.push_back(tag);
        modelA  = !vrst ? 8'd0 : vin;
        @(posedge clock);
        #1;
        popped = expQ.pop_front();
        ptag   = tagQ.pop_front();
        checkOutput(popped, ptag);
    endtask

    task automatic checkOutput(input logic [8:0] expv, input string tag);
        vectors++;
        assert (out === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: out=%0d expected=%0d", tag, out, expv);
        end
    endtask

    initial begin
        in      = 8'd0;
        op      = 2'd0;
        reset_n = 1'b0;
        modelA  = 8'd0;
        @(negedge clock);

        applyStimulus(8'd0,   2'd0, 1'b0, 1'b0, 9'd0,   "reset");
        applyStimulus(8'd0,   2'd0, 1'b1, 1'b0, 9'd0,   "buf_zero");
        applyStimulus(8'd9,   2'd0, 1'b1, 1'b0, 9'd0,   "buf_latency1");
        applyStimulus(8'd9,   2'd0, 1'b1, 1'b0, 9'd9,   "buf_latency2");

        applyStimulus(8'd9,   2'd1, 1'b1, 1'b0, 9'd11,  "op_add2");
        applyStimulus(8'd9,   2'd2, 1'b1, 1'b0, 9'd18,  "op_shl1");
        applyStimulus(8'd9,   2'd3, 1'b1, 1'b0, 9'd2,   "op_popcnt");

        applyStimulus(8'd143, 2'd3, 1'b1, 1'b0, 9'd2,   "pc_pipe1");
        applyStimulus(8'd143, 2'd3, 1'b1, 1'b0, 9'd5,   "pc_pipe2");

        applyStimulus(8'd255, 2'd0, 1'b1, 1'b0, 9'd143, "max_load");
        applyStimulus(8'd255, 2'd0, 1'b1, 1'b0, 9'd255, "max_pass");
        applyStimulus(8'd255, 2'd1, 1'b1, 1'b0, 9'd257, "max_add2");
        applyStimulus(8'd255, 2'd2, 1'b1, 1'b0, 9'd510, "max_shl1");
        applyStimulus(8'd0,   2'd3, 1'b1, 1'b0, 9'd8,   "max_popcnt");
        applyStimulus(8'd0,   2'd3, 1'b1, 1'b0, 9'd0,   "zero_popcnt");

        applyStimulus(8'd200, 2'd2, 1'b1, 1'b0, 9'd0,   "mid_load");
        applyStimulus(8'd200, 2'd2, 1'b1, 1'b0, 9'd400, "mid_shl1");
        applyStimulus(8'd200, 2'd2, 1'b0, 1'b0, 9'd0,   "mid_reset");
        applyStimulus(8'd0,   2'd2, 1'b1, 1'b0, 9'd0,   "post_reset_shl1");

        applyStimulus(8'd77,  2'd1, 1'b0, 1'b0, 9'd0,   "reset_again");
        applyStimulus(8'd77,  2'd1, 1'b1, 1'b0, 9'd2,   "post_reset_add2");
        applyStimulus(8'd77,  2'd0, 1'b1, 1'b0, 9'd77,  "post_reset_pass");

        for (int i = 0; i < 1200; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 49) != 0), 1'b1, 9'd0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
